// File: rtl/fifo_pkg.sv
// Shared sizing for the RAM-backed FIFO: a 16-entry x 8-bit buffer.
// FIFO_CW is the occupancy-count width. It holds 0..FIFO_DEPTH, so it is one bit
// wider than an address.
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FIFO_AW    = 4;
  localparam int unsigned FIFO_DW    = 8;
  localparam int unsigned FIFO_CW    = FIFO_AW + 1;

  typedef logic [FIFO_AW-1:0] fifo_addr_t;
  typedef logic [FIFO_DW-1:0] fifo_data_t;
  typedef logic [FIFO_CW-1:0] fifo_cnt_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Bundles the push/pop request side and the dual-port RAM strobes of ram_fifo_ctrl.
//   slave  : the controller. It takes the requests and RAM read data, and drives
//            the flags and RAM strobes.
//   master : the environment. It is the producer/consumer plus the RAM.
// The optional overflow/underflow flags exist only when FIFO_ERR_FLAGS_EN is defined.
import fifo_pkg::*;

interface ram_fifo_ctrl_if #(
  parameter int unsigned AW = FIFO_AW,
  parameter int unsigned DW = FIFO_DW
);
  logic          push;
  logic [DW-1:0] push_data;
  logic          pop;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ram_rst_n;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  modport slave (
    input  push, push_data, pop, ram_rd_data,
    output pop_data, pop_valid, full, empty, count,
           ram_rst_n, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr
`ifdef FIFO_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );

  modport master (
    output push, push_data, pop, ram_rd_data,
    input  pop_data, pop_valid, full, empty, count,
           ram_rst_n, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr
`ifdef FIFO_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

endinterface

// File: rtl/fifo_ptr.sv
// AW-bit wrapping pointer register. It wraps from 2**AW-1 to 0 by natural overflow.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, which clears the pointer to 0
//   inc : advance the pointer by one on this edge
//   ptr : current pointer value
module fifo_ptr #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: a FIFO controller that makes a 16x8 dual-port RAM with registered
// reads behave as a first-in first-out buffer.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : ram_fifo_ctrl_if.slave. It carries the push/pop requests, pop_data and
//         pop_valid, the full/empty/count flags and the RAM strobes.
// With FIFO_ERR_FLAGS_EN defined, the block adds the sticky overflow and underflow
// flags. Only rst clears them.
import fifo_pkg::*;

module ram_fifo_ctrl #(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned AW    = FIFO_AW,
  parameter int unsigned DW    = FIFO_DW
) (
  input  logic            clk,
  input  logic            rst,
  ram_fifo_ctrl_if.slave  bus
);

  logic          push_ok;
  logic          pop_ok;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          pop_valid_q;
  logic [DW-1:0] wr_data;

  // Flags come straight from the count register, so acceptance never depends on the
  // same-cycle request on the other side.
  assign bus.full  = (count_q == (AW+1)'(DEPTH));
  assign bus.empty = (count_q == '0);
  assign bus.count = count_q;

  assign push_ok = bus.push & ~bus.full;
  assign pop_ok  = bus.pop  & ~bus.empty;

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .ptr (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      pop_valid_q <= pop_ok;
    end
  end

  assign wr_data         = bus.push_data;
  assign bus.ram_rst_n   = ~rst;
  assign bus.ram_wr_en   = push_ok;
  assign bus.ram_wr_addr = wr_ptr;
  assign bus.ram_wr_data = wr_data;
  assign bus.ram_rd_en   = pop_ok;
  assign bus.ram_rd_addr = rd_ptr;
  // The RAM registers its read, so the data lines up with pop_valid without extra staging.
  assign bus.pop_data    = bus.ram_rd_data;
  assign bus.pop_valid   = pop_valid_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push && bus.full)  overflow_q  <= 1'b1;
      if (bus.pop  && bus.empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl, built around a behavioural 16x8 registered-read RAM.
// At each accepted pop, the stimulus pushes the expected entry into exp_q. A separate
// monitor at the falling edge pops exp_q and compares it whenever pop_valid is high.
module tb_ram_fifo_ctrl;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if bus ();

  ram_fifo_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: synchronous reset, registered read
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (!bus.ram_rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      bus.ram_rd_data <= 8'h00;
    end else begin
      if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
      if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor at the falling edge: every pop_valid must match the oldest expected
  // entry, and every expected entry must appear.
  always @(negedge clk) begin
    if (bus.pop_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got pop_valid=1 data=0x%0h, expected pop_valid=0",
                 bus.pop_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.pop_data !== e) begin
          errors++;
          $display("FAIL pop_data: got 0x%0h, expected 0x%0h", bus.pop_data, e);
        end
      end
    end else if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pop_missing: got pop_valid=%b, expected 1 with 0x%0h",
               bus.pop_valid, exp_q[0]);
      void'(exp_q.pop_front());
    end
  end

  // Apply one cycle of push/pop. The reference queue decides acceptance from the
  // pre-edge occupancy.
  task automatic cyc(input logic ps, input logic [7:0] d, input logic pp);
    logic       pop_acc;
    logic       push_acc;
    logic [7:0] pv;
    bus.push      = ps;
    bus.push_data = d;
    bus.pop       = pp;
    pop_acc  = pp && (model_q.size() > 0);
    push_acc = ps && (model_q.size() < 16);
    pv = 8'h00;
    if (pop_acc) pv = model_q.pop_front();
    if (push_acc) model_q.push_back(d);
    @(posedge clk);
    if (pop_acc) exp_q.push_back(pv);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
  endtask

  initial begin
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_data = 8'h00;

    // Reset then idle
    do_reset(2);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("rst_wr_en", 32'(bus.ram_wr_en), 32'd0);
    chk("rst_rd_en", 32'(bus.ram_rd_en), 32'd0);

    // Pop while empty: the pop is rejected with no strobe
    bus.pop = 1'b1;
    #1;
    chk("empty_pop_rd_en", 32'(bus.ram_rd_en), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("underflow_set", 32'(bus.underflow), 32'd1);
    chk("overflow_clear", 32'(bus.overflow), 32'd0);
`endif

    // Fill and drain
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_count", 32'(bus.count), 32'd0);

    // Wrap-around: both pointers go to 10, then wr_ptr wraps to 6
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0);
    chk("wrap_wr_addr", 32'(bus.ram_wr_addr), 32'd6);
    chk("wrap_rd_addr", 32'(bus.ram_rd_addr), 32'd10);
    chk("wrap_count", 32'(bus.count), 32'd12);
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("wrap_empty", 32'(bus.empty), 32'd1);

    // Empty with push and pop together: the push wins, and the monitor flags any pop_valid
    cyc(1'b1, 8'h55, 1'b1);
    chk("sim_empty_count", 32'(bus.count), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("sim_empty_drained", 32'(bus.empty), 32'd1);

    // Full with push and pop together: the pop wins and 0xEE is never stored
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    bus.push = 1'b1;
    bus.push_data = 8'hEE;
    #1;
    chk("full_push_wr_en", 32'(bus.ram_wr_en), 32'd0);
    cyc(1'b1, 8'hEE, 1'b0);
    chk("full_push_count", 32'(bus.count), 32'd16);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow_set", 32'(bus.overflow), 32'd1);
`endif
    cyc(1'b1, 8'hEE, 1'b1);
    chk("sim_full_count", 32'(bus.count), 32'd15);
    chk("sim_full_not_full", 32'(bus.full), 32'd0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("sim_full_drained", 32'(bus.empty), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow_sticky", 32'(bus.overflow), 32'd1);
    chk("underflow_sticky", 32'(bus.underflow), 32'd1);
`endif

    // Reset mid-operation: the pop is accepted at edge N and rst is sampled at edge N+1
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
    chk("mid_count5", 32'(bus.count), 32'd5);
    cyc(1'b0, 8'h00, 1'b1);
    do_reset(1);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    chk("mid_rst_pop_valid", 32'(bus.pop_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_underflow", 32'(bus.underflow), 32'd0);
`endif
    // After reset, the FIFO must work from a clean state again
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of the 16x8 dual-port RAM and turns it into a 16-entry, 8-bit first-in first-out buffer. It converts a push/pop request interface into the RAM's write-enable/address and read-enable/address strobes. It keeps the read and write pointers and the occupancy count, and returns the RAM's read data to the consumer with a one-cycle valid strobe. Producers and consumers never address the RAM directly.

## Interface
- DEPTH, 16: number of RAM entries; must equal 2**AW.
- AW, 4: RAM address width.
- DW, 8: data width.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- push  in  1  write request from producer.
- push_data  in  DW  data to store, sampled when a push is accepted.
- pop  in  1  read request from consumer.
- pop_data  out  DW  read data to consumer; combinational copy of ram_rd_data.
- pop_valid  out  1  pop_data holds the entry of a pop accepted on the previous edge.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  AW+1  current occupancy, 0..DEPTH.
- ram_rst_n  out  1  RAM reset, combinational ~rst.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  AW  RAM write address (= wr_ptr).
- ram_wr_data  out  DW  RAM write data (= push_data).
- ram_rd_en  out  1  RAM read enable.
- ram_rd_addr  out  AW  RAM read address (= rd_ptr).
- ram_rd_data  in  DW  RAM registered read-data output.

## Operation
- Acceptance, combinational: push_ok = push & ~full; pop_ok = pop & ~empty. ram_wr_en = push_ok; ram_rd_en = pop_ok. The RAM and the controller act on the same clock edge.
- Registered state: wr_ptr[AW-1:0], rd_ptr[AW-1:0], count[AW:0], pop_valid.
- On each edge with push_ok, wr_ptr increments. On each edge with pop_ok, rd_ptr increments. Both pointers wrap from DEPTH-1 to 0 by natural AW-bit overflow.
- count: +1 on push_ok only; -1 on pop_ok only; unchanged when both or neither occur.
- pop_valid <= pop_ok. There is no other output pipeline.
- Empty with push and pop together: the push is accepted and the pop is rejected. There is no write-to-read bypass, so the entry becomes readable on the following cycle.
- Full with push and pop together: the pop is accepted and the push is rejected. The producer retries; full deasserts on the next cycle.
- Not empty and not full with push and pop together: both are accepted. wr_ptr never equals rd_ptr in this case, so there is no same-address conflict.
- Rejected requests change no state and generate no RAM strobe.
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, pop_valid = 0, so empty = 1 and full = 0.
- ram_rst_n is low for as long as rst is high, so RAM contents and read data clear together with the pointers.
- Reset mid-operation: any in-flight pop is abandoned and pop_valid is 0 on the cycle after reset. Buffered entries are lost.

## Timing
- Push latency: an entry pushed at edge N is poppable at edge N+1 (empty falls after edge N).
- Pop latency: a pop accepted at edge N gives pop_valid = 1 and the entry on pop_data during cycle N+1.
- Back-to-back pops: one entry per cycle, with pop_valid continuously high.
- Throughput: one push and one pop per cycle, sustained.
- full, empty and count are registered-derived and glitch-free; push_ok and pop_ok are combinational from them.

## Configuration
- FIFO_ERR_FLAGS_EN: when defined, the block adds outputs overflow (1) and underflow (1).
  - overflow is set on an edge with push & full; underflow is set on an edge with pop & empty.
  - Both flags are sticky and are cleared only by rst; reset value is 0.
- Without the macro, these ports and their registers do not exist, and rejected requests are silently dropped.

## Structure
- Shared package fifo_pkg: FIFO_DEPTH = 16, FIFO_AW = 4, FIFO_DW = 8, FIFO_CW = FIFO_AW+1, and typedefs fifo_addr_t, fifo_data_t and fifo_cnt_t.
- One sub-module, fifo_ptr: an AW-bit wrapping pointer register with inputs clk, rst and inc and output ptr. It is instantiated twice, once for wr_ptr and once for rd_ptr.
- All flag and count logic lives in ram_fifo_ctrl.

## Test plan
- Reset then idle: hold rst for 2 cycles -> empty = 1, full = 0, count = 0, pop_valid = 0, ram_wr_en = 0, ram_rd_en = 0.
- Fill and drain: push 0x10..0x1F on 16 consecutive cycles -> full = 1 and count = 16. Then pop 16 times -> pop_data is 0x10..0x1F in order with pop_valid high each cycle after pop; empty = 1 at the end.
- Wrap-around: push 10 and pop 10, then push 12 entries 0xA0..0xAB -> wr_ptr wraps to 6. Popping all 12 returns 0xA0..0xAB in order.
- Simultaneous at boundaries:
  - When empty, push 0x55 together with pop -> count = 1, no pop_valid on the next cycle; the next pop returns 0x55.
  - When full, push together with pop -> count stays 16 - 1 = 15 and the pushed data is not written.
- Reset mid-operation: with count = 5 and a pop accepted at edge N, assert rst at edge N+1 -> count = 0 and empty = 1 after that edge; pop_valid = 0 on the cycle after reset.
- With FIFO_ERR_FLAGS_EN: push while full -> overflow = 1 and it stays 1 through later normal traffic. Pop while empty -> underflow = 1. rst clears both.
